// File: rtl/hack_cpu_ctrl.sv
// Hack CPU sequencer: fetches instructions, runs the A/C instruction flow
// against an external ALU and drives the instruction/data memory handshakes.
module hack_cpu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    output logic [14:0] instr_addr,
    input  logic        instr_ack,
    input  logic [15:0] instr_data,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [14:0] addressM,
    output logic [15:0] outM,
    input  logic [15:0] inM,
    input  logic        mem_ack,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctrl,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng
);

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {FETCH, MEM_RD, EXEC, MEM_WR} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] mreg_q, mreg_d;
    logic [DW-1:0] res_q, res_d;
    logic          instr_req_q, instr_req_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] addr_m_q, addr_m_d;
    logic [DW-1:0] out_m_q, out_m_d;
    logic [DW-1:0] alu_x_q, alu_x_d;
    logic [DW-1:0] alu_y_q, alu_y_d;
    logic [CW-1:0] alu_ctrl_q, alu_ctrl_d;
    logic          take_jump;

    // Next-state, architectural updates and registered bus outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        a_d        = a_q;
        d_d        = d_q;
        ir_d       = ir_q;
        mreg_d     = mreg_q;
        res_d      = res_q;
        addr_m_d   = addr_m_q;
        out_m_d    = out_m_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        alu_ctrl_d = '0;
        take_jump  = 1'b0;

        case (state_q)
            FETCH: begin
                if (instr_req_q && instr_ack) begin
                    ir_d    = instr_data;
                    state_d = (instr_data[15] && instr_data[12]) ? MEM_RD : EXEC;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    mreg_d  = inM;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                if (!ir_q[15]) begin
                    a_d  = {1'b0, ir_q[14:0]};
                    pc_d = pc_q + AW'(1);
                end else begin
                    res_d = alu_out;
                    if (ir_q[5]) a_d = alu_out;
                    if (ir_q[4]) d_d = alu_out;
                    take_jump = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr)
                              | (ir_q[0] & ~alu_ng & ~alu_zr);
                    // Jump target uses A as it was before this instruction writes it.
                    pc_d = take_jump ? a_q[AW-1:0] : pc_q + AW'(1);
                    if (ir_q[3]) state_d = MEM_WR;
                end
            end
            MEM_WR: begin
                if (mem_ack) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        instr_req_d = (state_d == FETCH);
        mem_rd_d    = (state_d == MEM_RD);
        mem_wr_d    = (state_d == MEM_WR);

        // Latch addresses/data only on entry so they stay stable while waiting.
        if (state_d == MEM_RD && state_q != MEM_RD) addr_m_d = a_q[AW-1:0];
        if (state_d == MEM_WR && state_q != MEM_WR) begin
            addr_m_d = a_q[AW-1:0];
            out_m_d  = alu_out;
        end

        if (state_d == EXEC) begin
            alu_x_d = d_q;
            alu_y_d = ir_d[12] ? mreg_d : a_q;
            if (ir_d[15]) alu_ctrl_d = ir_d[11:6];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            a_q         <= '0;
            d_q         <= '0;
            ir_q        <= '0;
            mreg_q      <= '0;
            res_q       <= '0;
            instr_req_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            addr_m_q    <= '0;
            out_m_q     <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_ctrl_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            d_q         <= d_d;
            ir_q        <= ir_d;
            mreg_q      <= mreg_d;
            res_q       <= res_d;
            instr_req_q <= instr_req_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            addr_m_q    <= addr_m_d;
            out_m_q     <= out_m_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            alu_ctrl_q  <= alu_ctrl_d;
        end
    end

    assign instr_req  = instr_req_q;
    assign instr_addr = pc_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign addressM   = addr_m_q;
    assign outM       = out_m_q;
    assign alu_x      = alu_x_q;
    assign alu_y      = alu_y_q;
    assign alu_ctrl   = alu_ctrl_q;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: acts as instruction ROM, data RAM and ALU, and
// checks every bus transaction against an instruction-level Hack model.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req;
    logic [14:0] instr_addr;
    logic        instr_ack;
    logic [15:0] instr_data;
    logic        mem_rd, mem_wr;
    logic [14:0] addressM;
    logic [15:0] outM, inM;
    logic        mem_ack;
    logic [15:0] alu_x, alu_y;
    logic [5:0]  alu_ctrl;
    logic [15:0] alu_out;
    logic        alu_zr, alu_ng;

    int n_tests = 0;
    int n_fail  = 0;

    // Instruction-level architectural model
    logic [14:0] m_pc;
    logic [15:0] m_a, m_d;
    logic [15:0] m_ram [32768];
    logic [15:0] obs_wr_data;
    logic [14:0] obs_wr_addr;

    hack_cpu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addressM(addressM), .outM(outM), .inM(inM), .mem_ack(mem_ack),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, r;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        r = c[1] ? xx + yy : xx & yy;
        if (c[0]) r = ~r;
        return r;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, alu_ctrl);
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("req_onehot", 16'($onehot0({instr_req, mem_rd, mem_wr})), 16'd1);
    endtask

    // Runs one instruction through the bus; abort_wr pulls reset while MEM_WR waits.
    task automatic do_instr(input logic [15:0] ir, input int fdly, input int mdly,
                            input bit abort_wr);
        logic        is_c, a_bit, jmp, zr, ng;
        logic [15:0] y, res, old_a;
        is_c  = ir[15];
        a_bit = is_c & ir[12];

        chk("fetch_req", 16'(instr_req), 16'd1);
        chk("fetch_addr", 16'(instr_addr), 16'(m_pc));
        chk("idle_ctrl", 16'(alu_ctrl), 16'd0);
        for (int i = 0; i < fdly; i++) begin
            mem_ack = 1'($urandom);
            tick();
            chk("fetch_hold_req", 16'(instr_req), 16'd1);
            chk("fetch_hold_addr", 16'(instr_addr), 16'(m_pc));
        end
        mem_ack    = 1'b0;
        instr_ack  = 1'b1;
        instr_data = ir;
        tick();
        instr_ack  = 1'b0;
        instr_data = 16'($urandom);

        if (a_bit) begin
            chk("rd_req", 16'(mem_rd), 16'd1);
            chk("rd_addr", 16'(addressM), 16'(m_a[14:0]));
            for (int i = 0; i < mdly; i++) begin
                instr_ack = 1'($urandom);
                tick();
                chk("rd_hold_req", 16'(mem_rd), 16'd1);
                chk("rd_hold_addr", 16'(addressM), 16'(m_a[14:0]));
            end
            instr_ack = 1'b0;
            mem_ack   = 1'b1;
            inM       = m_ram[m_a[14:0]];
            tick();
            mem_ack   = 1'b0;
            inM       = 16'($urandom);
        end

        // Now in the execute cycle.
        y     = a_bit ? m_ram[m_a[14:0]] : m_a;
        res   = hack_alu(m_d, y, ir[11:6]);
        zr    = (res == 16'h0000);
        ng    = res[15];
        jmp   = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
        old_a = m_a;
        chk("exec_no_req", 16'({instr_req, mem_rd, mem_wr}), 16'd0);
        if (is_c) begin
            chk("alu_x", alu_x, m_d);
            chk("alu_y", alu_y, y);
            chk("alu_ctrl", 16'(alu_ctrl), 16'(ir[11:6]));
        end
        tick();

        if (is_c && ir[3]) begin
            chk("wr_req", 16'(mem_wr), 16'd1);
            chk("wr_addr", 16'(addressM), 16'(old_a[14:0]));
            chk("wr_data", outM, res);
            obs_wr_addr = addressM;
            obs_wr_data = outM;
            if (abort_wr) begin
                #2 rst_n = 1'b0;
                mem_ack  = 1'b1;
                #1;
                chk("rst_mem_wr", 16'(mem_wr), 16'd0);
                chk("rst_addrM", 16'(addressM), 16'd0);
                chk("rst_outM", outM, 16'd0);
                m_pc = '0;
                m_a  = '0;
                m_d  = '0;
                tick();
                rst_n = 1'b1;
                chk("rel_req_low", 16'(instr_req), 16'd0);
                tick();
                mem_ack = 1'b0;
                chk("rel_req_high", 16'(instr_req), 16'd1);
                chk("rel_addr", 16'(instr_addr), 16'd0);
                return;
            end
            for (int i = 0; i < mdly; i++) begin
                instr_ack = 1'($urandom);
                tick();
                chk("wr_hold_req", 16'(mem_wr), 16'd1);
                chk("wr_hold_addr", 16'(addressM), 16'(old_a[14:0]));
                chk("wr_hold_data", outM, res);
            end
            instr_ack = 1'b0;
            mem_ack   = 1'b1;
            tick();
            mem_ack   = 1'b0;
            m_ram[old_a[14:0]] = res;
        end

        if (!is_c) begin
            m_a  = {1'b0, ir[14:0]};
            m_pc = m_pc + 15'd1;
        end else begin
            if (ir[5]) m_a = res;
            if (ir[4]) m_d = res;
            m_pc = jmp ? old_a[14:0] : m_pc + 15'd1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prog1 [6];
        logic [15:0] ir;
        int          fd, md;
        prog1 = '{16'h0002, 16'hEC10, 16'h0003, 16'hE090, 16'h0000, 16'hE308};

        rst_n = 1'b0;
        instr_ack = 1'b0;
        instr_data = '0;
        mem_ack = 1'b0;
        inM = '0;
        m_pc = '0;
        m_a = '0;
        m_d = '0;
        obs_wr_addr = '0;
        obs_wr_data = '0;
        for (int i = 0; i < 32768; i++) m_ram[i] = 16'($urandom);

        #1;
        chk("rst_instr_req", 16'(instr_req), 16'd0);
        chk("rst_mem_rd", 16'(mem_rd), 16'd0);
        chk("rst_mem_wr0", 16'(mem_wr), 16'd0);
        chk("rst_addressM", 16'(addressM), 16'd0);
        chk("rst_outM0", outM, 16'd0);
        chk("rst_instr_addr", 16'(instr_addr), 16'd0);
        @(negedge clk);
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        rst_n = 1'b1;
        chk("first_req_low", 16'(instr_req), 16'd0);
        tick();
        chk("first_req_high", 16'(instr_req), 16'd1);

        // D=2, D=D+3, M[0]=D
        foreach (prog1[i]) do_instr(prog1[i], 0, 0, 1'b0);
        chk("s1_wr_addr", 16'(obs_wr_addr), 16'h0000);
        chk("s1_wr_data", obs_wr_data, 16'h0005);

        // Unconditional jump
        do_instr(16'h000A, 0, 0, 1'b0);
        do_instr(16'hEA87, 0, 0, 1'b0);
        chk("s2_jmp_addr", 16'(instr_addr), 16'h000A);

        // D=M read, then write D back
        m_ram[16'h0020] = 16'h1234;
        do_instr(16'h0020, 0, 0, 1'b0);
        do_instr(16'hFC10, 0, 0, 1'b0);
        do_instr(16'hE308, 0, 0, 1'b0);
        chk("s3_wr_addr", 16'(obs_wr_addr), 16'h0020);
        chk("s3_wr_data", obs_wr_data, 16'h1234);

        // Delayed fetch ack
        do_instr(16'h0007, 3, 0, 1'b0);

        // PC wrap
        do_instr(16'h7FFF, 0, 0, 1'b0);
        do_instr(16'hEA87, 0, 0, 1'b0);
        chk("s5_at_top", 16'(instr_addr), 16'h7FFF);
        do_instr(16'h0005, 0, 0, 1'b0);
        chk("s5_wrap", 16'(instr_addr), 16'h0000);

        // Reset while a write is outstanding, then prove A=D=0
        do_instr(16'h0003, 0, 0, 1'b0);
        do_instr(16'hE308, 0, 2, 1'b1);
        do_instr(16'hE308, 0, 0, 1'b0);
        chk("s6_wr_addr", 16'(obs_wr_addr), 16'h0000);
        chk("s6_wr_data", obs_wr_data, 16'h0000);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) < 4) begin
                ir = {1'b0, 15'($urandom)};
            end else begin
                ir = 16'($urandom);
                ir[15] = 1'b1;
            end
            fd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            md = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_instr(ir, fd, md, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_cpu_ctrl.md
HACK_CPU_CTRL -- requirements
Module: hack_cpu_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1: the single clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- instr_req, output, 1: instruction fetch request.
- instr_addr, output, 15: fetch address; equals PC.
- instr_ack, input, 1: fetch complete; instr_data is valid in this cycle.
- instr_data, input, 16: instruction word.
- mem_rd, output, 1: data memory read request.
- mem_wr, output, 1: data memory write request.
- addressM, output, 15: data memory address.
- outM, output, 16: data memory write data.
- inM, input, 16: data memory read data; valid when mem_ack is high.
- mem_ack, input, 1: data memory access complete.
- alu_x, output, 16: ALU x operand.
- alu_y, output, 16: ALU y operand.
- alu_ctrl, output, 6: {zx,nx,zy,ny,f,no} to the 16-bit Hack ALU.
- alu_out, input, 16: ALU result.
- alu_zr, input, 1: ALU zero flag.
- alu_ng, input, 1: ALU negative flag.

Function
REQ-002 Internal state SHALL be: PC[14:0], A[15:0], D[15:0], IR[15:0], MREG[15:0], RES[15:0], and an FSM with states FETCH, MEM_RD, EXEC, MEM_WR.
REQ-003 FETCH: instr_req SHALL be 1 with instr_addr=PC held stable until a cycle in which instr_ack=1.
- In that cycle IR<=instr_data.
- Next state: EXEC if IR[15]=0 or a-bit=0; otherwise MEM_RD.
REQ-004 A-instruction (IR[15]=0), in EXEC: A<={1'b0,IR[14:0]}, PC<=PC+1, next state FETCH.
REQ-005 C-instruction field decode SHALL be: a=IR[12], alu_ctrl=IR[11:6], dest{A,D,M}=IR[5:3], jump{j1,j2,j3}=IR[2:0]; IR[14:13] are ignored.
REQ-006 MEM_RD: mem_rd=1 and addressM=A[14:0] held stable until mem_ack=1; in that cycle MREG<=inM, next state EXEC.
REQ-007 EXEC (C-instruction): the block SHALL drive alu_x=D, alu_y=(a ? MREG : A), alu_ctrl=IR[11:6], and sample alu_out, alu_zr and alu_ng in the same cycle.
REQ-008 In EXEC, RES<=alu_out; if dest A, A<=alu_out; if dest D, D<=alu_out.
REQ-009 Jump and PC update in EXEC:
- Jump is taken iff (j1&alu_ng)|(j2&alu_zr)|(j3&~alu_ng&~alu_zr).
- If taken, PC<=A[14:0] using A's value before this instruction's write; otherwise PC<=PC+1.
REQ-010 From EXEC, the next state SHALL be MEM_WR if dest M=1, else FETCH.
REQ-011 MEM_WR: mem_wr=1, outM=RES and addressM=pre-instruction A[14:0] (latched at EXEC) SHALL be held stable until mem_ack=1, then next state FETCH.
REQ-012 PC increment SHALL wrap from 0x7FFF to 0x0000; A and D arithmetic is modulo 2^16 (external ALU).
REQ-013 instr_ack outside FETCH and mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-014 mem_rd and mem_wr SHALL never be high together; at most one request output is high in any cycle.
REQ-015 Latency with zero-wait acks SHALL be:
- A-instruction: 2 cycles.
- C-instruction: 2 cycles, +1 if a=1, +1 if dest M.
REQ-016 When idle, alu_ctrl SHALL be 6'b0 and alu_x/alu_y are don't-care.

Reset
REQ-017 rst_n=0 SHALL immediately force:
- PC, A, D, IR, MREG and RES to 0.
- State to FETCH.
- instr_req, mem_rd and mem_wr to 0.
- addressM and outM to 0.
REQ-018 instr_req SHALL first assert in the first clk cycle after rst_n deasserts.
REQ-019 Reset asserted during any in-flight request SHALL abort it with no architectural update; any late ack after reset is ignored.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Program 0x0002, 0xEC10, 0x0003, 0xE090, 0x0000, 0xE308 -> mem_wr=1, addressM=0, outM=0x0005; D=5.
- A=10, then 0xEA87 (0;JMP) -> next instr_addr=0x000A.
- A=0x0020, then 0xFC10 (D=M) with inM=0x1234 -> mem_rd with addressM=0x0020, then D=0x1234.
- instr_ack delayed 3 cycles -> instr_req held, instr_addr stable, no state change.
- PC=0x7FFF executing an A-instruction -> next instr_addr=0x0000.
- rst_n low while in MEM_WR -> mem_wr=0 asynchronously; after release instr_addr=0, A=D=0.
